s400_lamp_monitor: RTL and testbench

- Downstream safety stage for the s400 traffic-light controller.
- Consumes the six lamp outputs GRN1/YLW1/RED1/GRN2/YLW2/RED2 and forwards them, registered, to the lamp drivers.
- Continuously checks them for conflicting greens, invalid head patterns, skipped yellow and stuck controller.
- On any violation it latches a fault code and forces both heads to flashing red until reset.

---
 rtl/s400_lamp_monitor_if.sv | 21 ++
 rtl/s400_lamp_monitor.sv | 179 +++++++++++++++++
 tb/tb_s400_lamp_monitor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/s400_lamp_monitor_if.sv
// Lamp bus between the s400 controller, the safety monitor and the lamp drivers.
// The controller side drives the requests; the monitor drives the lamp outputs and status.
interface s400_lamp_monitor_if;
  logic       GRN1, YLW1, RED1;
  logic       GRN2, YLW2, RED2;
  logic       LGRN1, LYLW1, LRED1;
  logic       LGRN2, LYLW2, LRED2;
  logic       FAULT;
  logic [2:0] FAULT_CODE;
  logic       FLASH;

  modport master (
    output GRN1, YLW1, RED1, GRN2, YLW2, RED2,
    input  LGRN1, LYLW1, LRED1, LGRN2, LYLW2, LRED2, FAULT, FAULT_CODE, FLASH
  );

  modport slave (
    input  GRN1, YLW1, RED1, GRN2, YLW2, RED2,
    output LGRN1, LYLW1, LRED1, LGRN2, LYLW2, LRED2, FAULT, FAULT_CODE, FLASH
  );
endinterface

// File: rtl/s400_lamp_monitor.sv
// Safety stage between the s400 controller and the lamp drivers.
// Forwards the six lamp requests one cycle late, and on a conflicting green,
// a head dark/invalid too long, a skipped yellow or a stuck controller it
// latches a fault code and flashes both reds until CLR.
module s400_lamp_monitor #(
  parameter int STARTUP    = 4,
  parameter int DARK_TOL   = 2,
  parameter int WDOG_W     = 16,
  parameter int WDOG_MAX   = 60000,
  parameter int FLASH_HALF = 8,
  parameter bit SEQ_CHK    = 1'b1
) (
  input logic                CK,
  input logic                CLR,
  s400_lamp_monitor_if.slave lamp
);

  localparam int SCW = $clog2(STARTUP) + 1;
  localparam int DCW = $clog2(DARK_TOL) + 1;
  localparam int FCW = $clog2(FLASH_HALF) + 1;
  localparam logic [5:0] ALL_RED = 6'b001001;

  typedef enum logic [1:0] {ST_START, ST_MON, ST_FLASH} state_t;
  // Last one-hot state seen on a head; H_NONE until one has been seen.
  typedef enum logic [1:0] {H_NONE, H_GRN, H_YLW, H_RED} head_t;

  function automatic head_t head_of(input logic [2:0] h);
    head_t r;
    case (h)
      3'b100:  r = H_GRN;
      3'b010:  r = H_YLW;
      3'b001:  r = H_RED;
      default: r = H_NONE;
    endcase
    return r;
  endfunction

  // {GRN1,YLW1,RED1,GRN2,YLW2,RED2}
  logic [5:0] in_v;
  assign in_v = {lamp.GRN1, lamp.YLW1, lamp.RED1, lamp.GRN2, lamp.YLW2, lamp.RED2};

  state_t            state_q, state_d;
  logic [SCW-1:0]    st_cnt_q, st_cnt_d;
  logic [DCW-1:0]    dark1_q, dark1_d, dark2_q, dark2_d;
  head_t             last1_q, last1_d, last2_q, last2_d;
  logic [5:0]        prev_q, prev_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [FCW-1:0]    fl_cnt_q, fl_cnt_d;
  logic [5:0]        lamp_q, lamp_d;
  logic              fault_q, fault_d;
  logic [2:0]        code_q, code_d;

  head_t      cur1, cur2;
  logic       chk_conf, chk_d1, chk_d2, chk_skip, chk_wd, same;
  logic [2:0] code_sel;

  // Violation checks on the live inputs; lowest code wins.
  always_comb begin
    cur1     = head_of(in_v[5:3]);
    cur2     = head_of(in_v[2:0]);
    same     = (in_v == prev_q);
    chk_conf = (in_v[5] | in_v[4]) & (in_v[2] | in_v[1]);
    chk_d1   = (cur1 == H_NONE) && (dark1_q >= DCW'(DARK_TOL - 1));
    chk_d2   = (cur2 == H_NONE) && (dark2_q >= DCW'(DARK_TOL - 1));
    chk_skip = SEQ_CHK && (((last1_q == H_GRN) && (cur1 == H_RED)) ||
                           ((last2_q == H_GRN) && (cur2 == H_RED)));
    chk_wd   = same && (wdog_q >= WDOG_W'(WDOG_MAX - 1));
    if (chk_conf)      code_sel = 3'd1;
    else if (chk_d1)   code_sel = 3'd2;
    else if (chk_d2)   code_sel = 3'd3;
    else if (chk_skip) code_sel = 3'd4;
    else if (chk_wd)   code_sel = 3'd5;
    else               code_sel = 3'd0;
  end

  // Next-state and registered-output logic for START / MONITOR / FLASH.
  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    dark1_d  = dark1_q;
    dark2_d  = dark2_q;
    last1_d  = last1_q;
    last2_d  = last2_q;
    prev_d   = prev_q;
    wdog_d   = wdog_q;
    fl_cnt_d = fl_cnt_q;
    lamp_d   = lamp_q;
    fault_d  = fault_q;
    code_d   = code_q;
    case (state_q)
      ST_START: begin
        lamp_d = ALL_RED;
        if (st_cnt_q == SCW'(STARTUP - 1)) begin
          // Seed history so the first monitored cycle compares against this one.
          state_d = ST_MON;
          prev_d  = in_v;
          wdog_d  = '0;
          last1_d = cur1;
          last2_d = cur2;
          dark1_d = '0;
          dark2_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end
      ST_MON: begin
        if (code_sel != 3'd0) begin
          // The offending pattern is replaced by the first flash-on frame.
          state_d  = ST_FLASH;
          fault_d  = 1'b1;
          code_d   = code_sel;
          lamp_d   = ALL_RED;
          fl_cnt_d = '0;
        end else begin
          lamp_d  = in_v;
          prev_d  = in_v;
          dark1_d = (cur1 == H_NONE) ? dark1_q + 1'b1 : '0;
          dark2_d = (cur2 == H_NONE) ? dark2_q + 1'b1 : '0;
          if (cur1 != H_NONE) last1_d = cur1;
          if (cur2 != H_NONE) last2_d = cur2;
          if (!same)                wdog_d = '0;
          else if (wdog_q != '1)    wdog_d = wdog_q + 1'b1;
        end
      end
      ST_FLASH: begin
        if (fl_cnt_q == FCW'(FLASH_HALF - 1)) begin
          fl_cnt_d = '0;
          lamp_d   = {2'b00, ~lamp_q[3], 2'b00, ~lamp_q[0]};
        end else begin
          fl_cnt_d = fl_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  // State register with synchronous reset to steady all-red START.
  always_ff @(posedge CK) begin
    if (CLR) begin
      state_q  <= ST_START;
      st_cnt_q <= '0;
      dark1_q  <= '0;
      dark2_q  <= '0;
      last1_q  <= H_NONE;
      last2_q  <= H_NONE;
      prev_q   <= '0;
      wdog_q   <= '0;
      fl_cnt_q <= '0;
      lamp_q   <= ALL_RED;
      fault_q  <= 1'b0;
      code_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      st_cnt_q <= st_cnt_d;
      dark1_q  <= dark1_d;
      dark2_q  <= dark2_d;
      last1_q  <= last1_d;
      last2_q  <= last2_d;
      prev_q   <= prev_d;
      wdog_q   <= wdog_d;
      fl_cnt_q <= fl_cnt_d;
      lamp_q   <= lamp_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  assign lamp.LGRN1      = lamp_q[5];
  assign lamp.LYLW1      = lamp_q[4];
  assign lamp.LRED1      = lamp_q[3];
  assign lamp.LGRN2      = lamp_q[2];
  assign lamp.LYLW2      = lamp_q[1];
  assign lamp.LRED2      = lamp_q[0];
  // FAULT and FLASH come from one flop so they can never disagree.
  assign lamp.FAULT      = fault_q;
  assign lamp.FLASH      = fault_q;
  assign lamp.FAULT_CODE = code_q;

endmodule

// File: tb/tb_s400_lamp_monitor.sv
// Bench for s400_lamp_monitor: two instances (yellow-skip check on / off) share
// one stimulus stream and are compared every cycle to a history-based model.
module tb_s400_lamp_monitor;
  localparam int STARTUP    = 4;
  localparam int DARK_TOL   = 2;
  localparam int WDOG_MAX   = 20;
  localparam int FLASH_HALF = 8;

  localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001, D = 3'b000;

  logic       ck = 1'b0;
  logic       clr = 1'b1;
  logic [5:0] in_v = {R, R};
  always #5 ck = ~ck;

  s400_lamp_monitor_if ifa();
  s400_lamp_monitor_if ifb();

  assign {ifa.GRN1, ifa.YLW1, ifa.RED1, ifa.GRN2, ifa.YLW2, ifa.RED2} = in_v;
  assign {ifb.GRN1, ifb.YLW1, ifb.RED1, ifb.GRN2, ifb.YLW2, ifb.RED2} = in_v;

  s400_lamp_monitor #(.STARTUP(STARTUP), .DARK_TOL(DARK_TOL), .WDOG_W(16),
    .WDOG_MAX(WDOG_MAX), .FLASH_HALF(FLASH_HALF), .SEQ_CHK(1'b1))
    dut_a (.CK(ck), .CLR(clr), .lamp(ifa.slave));
  s400_lamp_monitor #(.STARTUP(STARTUP), .DARK_TOL(DARK_TOL), .WDOG_W(16),
    .WDOG_MAX(WDOG_MAX), .FLASH_HALF(FLASH_HALF), .SEQ_CHK(1'b0))
    dut_b (.CK(ck), .CLR(clr), .lamp(ifb.slave));

  logic [10:0] obs_a, obs_b;
  assign obs_a = {ifa.LGRN1, ifa.LYLW1, ifa.LRED1, ifa.LGRN2, ifa.LYLW2, ifa.LRED2,
                  ifa.FAULT, ifa.FLASH, ifa.FAULT_CODE};
  assign obs_b = {ifb.LGRN1, ifb.LYLW1, ifb.LRED1, ifb.LGRN2, ifb.LYLW2, ifb.LRED2,
                  ifb.FAULT, ifb.FLASH, ifb.FAULT_CODE};

  // Model: mode 0=start, 1=monitor, 2=flash; hist holds every input vector
  // from the seed cycle onward and all checks are answered by scanning it.
  int          mode [2];
  int          scnt [2];
  int          fn   [2];
  logic [2:0]  code [2];
  logic [10:0] expv [2];
  logic [5:0]  hist [$];
  int          n_asrt = 0;
  int          n_fail = 0;

  function automatic logic [2:0] head(input logic [5:0] v, input int sh);
    return (sh == 3) ? v[5:3] : v[2:0];
  endfunction

  // Consecutive invalid monitored cycles for a head just before now.
  function automatic int dark_run(input int sh);
    int n = 0;
    for (int i = hist.size() - 1; i >= 1; i--) begin
      if ($onehot(head(hist[i], sh))) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit last_green(input int sh);
    for (int i = hist.size() - 1; i >= 0; i--)
      if ($onehot(head(hist[i], sh))) return head(hist[i], sh) == G;
    return 1'b0;
  endfunction

  function automatic logic [2:0] eval(input logic [5:0] v, input bit seq);
    logic [2:0] h1 = v[5:3];
    logic [2:0] h2 = v[2:0];
    int t = 0;
    if ((h1[2] | h1[1]) && (h2[2] | h2[1])) return 3'd1;
    if (!$onehot(h1) && dark_run(3) + 1 >= DARK_TOL) return 3'd2;
    if (!$onehot(h2) && dark_run(0) + 1 >= DARK_TOL) return 3'd3;
    if (seq && ((last_green(3) && h1 == R) || (last_green(0) && h2 == R))) return 3'd4;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != v) break;
      t++;
    end
    if (t >= WDOG_MAX) return 3'd5;
    return 3'd0;
  endfunction

  task automatic model_step(input logic c, input logic [5:0] v);
    bit enter = 1'b0;
    bit r;
    logic [2:0] cd;
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        mode[k] = 0; scnt[k] = 0; code[k] = 3'd0;
        expv[k] = {R, R, 5'b0};
      end else if (mode[k] == 0) begin
        scnt[k]++;
        expv[k] = {R, R, 5'b0};
        if (scnt[k] == STARTUP) begin mode[k] = 1; enter = 1'b1; end
      end else if (mode[k] == 1) begin
        cd = eval(v, k == 0);
        if (cd != 3'd0) begin
          mode[k] = 2; fn[k] = 0; code[k] = cd;
          expv[k] = {R, R, 2'b11, cd};
        end else begin
          expv[k] = {v, 5'b0};
        end
      end else begin
        fn[k]++;
        r = ((fn[k] / FLASH_HALF) % 2) == 0;
        expv[k] = {2'b00, r, 2'b00, r, 2'b11, code[k]};
      end
    end
    if (c) hist.delete();
    else if (enter) begin hist.delete(); hist.push_back(v); end
    else if (hist.size() > 0) hist.push_back(v);
  endtask

  task automatic check(input string tag);
    n_asrt++;
    assert (obs_a === expv[0]) else begin
      n_fail++;
      $error("FAIL %s inst_a observed=%b expected=%b", tag, obs_a, expv[0]);
    end
    n_asrt++;
    assert (obs_b === expv[1]) else begin
      n_fail++;
      $error("FAIL %s inst_b observed=%b expected=%b", tag, obs_b, expv[1]);
    end
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic cyc(input logic c, input logic [5:0] v, input string tag);
    clr  = c;
    in_v = v;
    @(posedge ck);
    model_step(c, v);
    @(negedge ck);
    check(tag);
  endtask

  logic [5:0] ph [6];
  int p, d;

  initial begin
    ph[0] = {G, R}; ph[1] = {Y, R}; ph[2] = {R, R};
    ph[3] = {R, G}; ph[4] = {R, Y}; ph[5] = {R, R};
    @(negedge ck);

    // Reset, startup and a legal sequence
    repeat (2) cyc(1'b1, {G, R}, "reset");
    repeat (STARTUP) cyc(1'b0, {G, R}, "startup");
    repeat (10) cyc(1'b0, {G, R}, "legal_g1");
    repeat (3)  cyc(1'b0, {Y, R}, "legal_y1");
    repeat (5)  cyc(1'b0, {R, G}, "legal_g2");
    repeat (3)  cyc(1'b0, {R, Y}, "legal_y2");
    repeat (2)  cyc(1'b0, {R, R}, "legal_rr");
    p = 0;
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(1, 8);
      repeat (d) cyc(1'b0, ph[p], "legal_rand");
      p = (p + 1) % 6;
    end

    // Conflict, flash cadence, later violation ignored
    cyc(1'b0, {G, Y}, "conflict");
    repeat (10) cyc(1'b0, {R, G}, "flash");
    repeat (3)  cyc(1'b0, {D, D}, "flash_late_viol");
    repeat (12) cyc(1'b0, {G, G}, "flash_late_viol2");

    // Reset mid-flash and recovery
    cyc(1'b1, {R, G}, "reset_mid_flash");
    repeat (STARTUP) cyc(1'b0, {R, G}, "restart");
    repeat (3) cyc(1'b0, {R, G}, "remon");

    // Dark tolerance: one dark cycle passes, two fault
    cyc(1'b0, {D, G}, "dark_one");
    cyc(1'b0, {R, G}, "dark_back");
    cyc(1'b0, {D, G}, "dark_two_a");
    cyc(1'b0, {D, G}, "dark_two_b");
    repeat (3) cyc(1'b0, {R, G}, "dark_flash");

    // Yellow skip: inst_a faults, inst_b keeps going
    cyc(1'b1, {G, R}, "reset_skip");
    repeat (STARTUP) cyc(1'b0, {G, R}, "start_skip");
    repeat (2) cyc(1'b0, {G, R}, "pre_skip");
    cyc(1'b0, {R, R}, "skip");
    repeat (3) cyc(1'b0, {R, G}, "post_skip");
    // Conflict together with an invalid head pattern: conflict wins
    cyc(1'b0, {3'b110, G}, "prio_conf");
    repeat (2) cyc(1'b0, {R, G}, "prio_conf_hold");

    // Head-1 dark tolerance together with head-2 yellow skip
    cyc(1'b1, {R, G}, "reset_prio");
    repeat (STARTUP) cyc(1'b0, {R, G}, "start_prio");
    cyc(1'b0, {D, G}, "prio_dark1");
    cyc(1'b0, {D, R}, "prio_dark_skip");
    repeat (2) cyc(1'b0, {R, G}, "prio_hold");

    // Watchdog
    cyc(1'b1, {R, G}, "reset_wd");
    repeat (STARTUP) cyc(1'b0, {R, G}, "start_wd");
    repeat (WDOG_MAX + 4) cyc(1'b0, {R, G}, "watchdog");

    // Randomized mix of legal phases, random patterns and resets
    for (int rnd = 0; rnd < 8; rnd++) begin
      cyc(1'b1, ph[0], "rand_reset");
      p = 0; d = 0;
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          cyc(1'b0, 6'($urandom), "rand_pat");
        end else begin
          if (d == 0) begin
            p = (p + 1) % 6;
            d = $urandom_range(1, 6);
          end
          d--;
          cyc(1'b0, ph[p], "rand_legal");
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
